// File: rtl/bpt_update_scheduler_pkg.sv
// Shared branch-predictor definitions: 2-bit counter encoding, its update rule,
// the table clear value and the port-B scheduler state encoding.
package bpt_update_scheduler_pkg;

  typedef enum logic [1:0] {
    N_TAKE        = 2'd0,
    STRONG_N_TAKE = 2'd1,
    TAKE          = 2'd2,
    STRONG_TAKE   = 2'd3
  } state_t;

  localparam state_t CTR_INIT = N_TAKE;

  typedef enum logic [1:0] {
    S_INIT,
    S_IDLE,
    S_READ,
    S_WRITE
  } sched_state_t;

  // Saturating counter step; the encoding is not a plain up/down count.
  function automatic state_t ctr_next(input state_t cur, input logic mispredict);
    state_t nxt;
    nxt = cur;
    case (cur)
      STRONG_N_TAKE: nxt = mispredict ? N_TAKE        : STRONG_N_TAKE;
      N_TAKE:        nxt = mispredict ? TAKE          : STRONG_N_TAKE;
      TAKE:          nxt = mispredict ? N_TAKE        : STRONG_TAKE;
      STRONG_TAKE:   nxt = mispredict ? TAKE          : STRONG_TAKE;
      default:       nxt = cur;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/bpt_update_scheduler_if.sv
// Update-request, table port-B and status bundle of the BPT update scheduler.
interface bpt_update_scheduler_if #(
  parameter int unsigned s_index    = 7,
  parameter int unsigned fifo_depth = 4
);
  localparam int unsigned CNT_W = $clog2(fifo_depth) + 1;

  logic               flush;
  logic               upd_valid;
  logic               upd_ready;
  logic [s_index-1:0] upd_index;
  logic               upd_mispredict;
  logic [s_index-1:0] tbl_addr;
  logic               tbl_wren;
  logic [1:0]         tbl_wdata;
  logic [1:0]         tbl_rdata;
  logic               init_busy;
  logic [CNT_W-1:0]   upd_pending;
  logic               upd_dropped;

  modport master (
    output flush, upd_valid, upd_index, upd_mispredict, tbl_rdata,
    input  upd_ready, tbl_addr, tbl_wren, tbl_wdata, init_busy, upd_pending, upd_dropped
  );

  modport slave (
    input  flush, upd_valid, upd_index, upd_mispredict, tbl_rdata,
    output upd_ready, tbl_addr, tbl_wren, tbl_wdata, init_busy, upd_pending, upd_dropped
  );
endinterface

// File: rtl/bpt_update_fifo.sv
// Synchronous FIFO of resolved-branch updates {index, mispredict}.
module bpt_update_fifo #(
  parameter int unsigned idx_w = 7,
  parameter int unsigned depth = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   push,
  input  logic                   pop,
  input  logic [idx_w-1:0]       push_index,
  input  logic                   push_mispredict,
  output logic [idx_w-1:0]       head_index,
  output logic                   head_mispredict,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(depth):0] count
);
  localparam int unsigned PTR_W = $clog2(depth);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(depth);

  logic [idx_w-1:0] idx_mem_q  [depth];
  logic             misp_mem_q [depth];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) begin
      idx_mem_q[wr_ptr_q]  <= push_index;
      misp_mem_q[wr_ptr_q] <= push_mispredict;
    end
  end

  assign head_index      = idx_mem_q[rd_ptr_q];
  assign head_mispredict = misp_mem_q[rd_ptr_q];
  assign count           = count_q;

endmodule

// File: rtl/bpt_update_scheduler.sv
// Owner of BPT port B: sweeps the table to N_TAKE after reset/flush, then applies
// queued resolved-branch updates as two-cycle read-modify-writes.
module bpt_update_scheduler
  import bpt_update_scheduler_pkg::*;
#(
  parameter int unsigned s_index    = 7,
  parameter int unsigned fifo_depth = 4
) (
  input logic                    clk,
  input logic                    rst,
  bpt_update_scheduler_if.slave  bus
);
  localparam int unsigned CNT_W = $clog2(fifo_depth) + 1;
  localparam logic [s_index-1:0] LAST_ADDR = '1;

  sched_state_t       state_q, state_d;
  logic [s_index-1:0] sweep_q, sweep_d;
  logic [s_index-1:0] idx_q, idx_d;
  logic               misp_q, misp_d;

  logic               push, pop, full, empty, ready, in_init;
  logic [s_index-1:0] head_index;
  logic               head_misp;
  logic [CNT_W-1:0]   count;

  logic               wren_c;
  logic [s_index-1:0] addr_c;
  state_t             wdata_c;

  assign in_init = (state_q == S_INIT);
  // Ready comes from registered occupancy only; a pop in the same cycle does not help.
  assign ready   = rst & ~bus.flush & (in_init | ~full);
  assign push    = bus.upd_valid & ready & ~in_init;
  assign pop     = (state_q == S_READ);

  bpt_update_fifo #(
    .idx_w (s_index),
    .depth (fifo_depth)
  ) u_fifo (
    .clk             (clk),
    .rst             (rst),
    .clear           (bus.flush),
    .push            (push),
    .pop             (pop),
    .push_index      (bus.upd_index),
    .push_mispredict (bus.upd_mispredict),
    .head_index      (head_index),
    .head_mispredict (head_misp),
    .full            (full),
    .empty           (empty),
    .count           (count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_INIT;
      sweep_q <= '0;
      idx_q   <= '0;
      misp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      idx_q   <= idx_d;
      misp_q  <= misp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    idx_d   = idx_q;
    misp_d  = misp_q;
    wren_c  = 1'b0;
    addr_c  = '0;
    wdata_c = CTR_INIT;
    case (state_q)
      S_INIT: begin
        addr_c  = sweep_q;
        wren_c  = 1'b1;
        wdata_c = CTR_INIT;
        sweep_d = sweep_q + 1'b1;
        if (sweep_q == LAST_ADDR) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (!empty) state_d = S_READ;
      end
      S_READ: begin
        addr_c  = head_index;
        idx_d   = head_index;
        misp_d  = head_misp;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        addr_c  = idx_q;
        wren_c  = 1'b1;
        wdata_c = ctr_next(state_t'(bus.tbl_rdata), misp_q);
        state_d = (!empty || push) ? S_READ : S_IDLE;
      end
      default: state_d = S_INIT;
    endcase
    // A write already on the port still completes; only the next state is redirected.
    if (bus.flush) begin
      state_d = S_INIT;
      sweep_d = '0;
    end
  end

  assign bus.tbl_addr    = addr_c;
  assign bus.tbl_wren    = wren_c & rst;
  assign bus.tbl_wdata   = wdata_c;
  assign bus.init_busy   = in_init;
  assign bus.upd_ready   = ready;
  assign bus.upd_pending = count;
  assign bus.upd_dropped = bus.upd_valid & ready & in_init;

endmodule

// File: doc/bpt_update_scheduler.md
Name: bpt_update_scheduler

Overview:
- Owns the single read/write port (port B) of the 2-bit branch prediction table; the fetch-side lookup port is not part of this block.
- Clears the table after reset or flush by sweeping every entry to N_TAKE, one entry per cycle.
- Queues resolved-branch updates in a small FIFO and applies each one as a two-cycle read-modify-write of the saturating counter.
- Sits between the branch-resolution stage and the table RAM, replacing the flip-flop table reset so the table can live in BRAM.

Parameters:
- s_index, 7, table index width; the table has 2**s_index entries.
- fifo_depth, 4, update FIFO depth; must be a power of two and at least 2.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  restart the clear sweep; discards the FIFO contents and any in-flight update.
- upd_valid  in  1  resolved-branch update presented.
- upd_ready  out  1  update can be accepted this cycle.
- upd_index  in  s_index  table index of the resolved branch.
- upd_mispredict  in  1  the resolved branch was mispredicted.
- tbl_addr  out  s_index  table port-B address.
- tbl_wren  out  1  table port-B write enable.
- tbl_wdata  out  2  table port-B write data.
- tbl_rdata  in  2  table port-B read data; valid one cycle after tbl_addr is presented with tbl_wren=0.
- init_busy  out  1  clear sweep in progress.
- upd_pending  out  $clog2(fifo_depth)+1  FIFO occupancy.
- upd_dropped  out  1  one-cycle pulse: an update was accepted during INIT and discarded.

Behaviour:
- Counter encoding: N_TAKE=0, STRONG_N_TAKE=1, TAKE=2, STRONG_TAKE=3.
- Counter update, written as state: mispredict result / correct result:
  - STRONG_N_TAKE: N_TAKE / STRONG_N_TAKE.
  - N_TAKE: TAKE / STRONG_N_TAKE.
  - TAKE: N_TAKE / STRONG_TAKE.
  - STRONG_TAKE: TAKE / STRONG_TAKE.
- FSM states: INIT, IDLE, READ, WRITE.
- Reset (rst low), applied immediately:
  - state=INIT, sweep counter=0, FIFO empty.
  - init_busy=1, upd_pending=0, upd_dropped=0, upd_ready=0.
  - tbl_wren forced to 0 for as long as rst is low.
- INIT:
  - Drives tbl_addr=sweep counter, tbl_wren=1, tbl_wdata=N_TAKE; counter increments each cycle.
  - The first sweep write happens in the first cycle after rst rises.
  - After the write to address 2**s_index-1, the next state is IDLE; the full sweep takes exactly 2**s_index cycles.
  - init_busy is 1 throughout INIT and 0 from the first IDLE cycle.
  - upd_ready=1; accepted updates are discarded with an upd_dropped pulse and never enter the FIFO.
- IDLE: tbl_wren=0. If the FIFO is non-empty, next state is READ.
- READ:
  - Pops the FIFO head, latches its index and mispredict flag.
  - Drives tbl_addr=index, tbl_wren=0.
  - Next state is WRITE.
- WRITE:
  - Drives tbl_addr=latched index, tbl_wren=1, tbl_wdata=next-state(tbl_rdata, flag).
  - Next state is READ if the FIFO is non-empty (including an entry pushed this cycle), else IDLE.
- Throughput: one update per 2 cycles.
- Latency: an update pushed at edge t into an empty FIFO gives READ in cycle t+1 and WRITE in cycle t+2; the table holds the new value after edge t+3.
- Back-to-back updates to the same index need no forwarding: the READ always follows the previous WRITE edge.
- upd_ready = !full outside INIT, from registered occupancy; no push bypass when full, even if a pop happens in the same cycle.
- Same-cycle push and pop leave upd_pending unchanged.
- Entries are processed strictly in FIFO order; a push with upd_ready=0 is ignored.
- flush (synchronous, any state):
  - Next state INIT, sweep counter=0, FIFO cleared.
  - An update in READ or WRITE is abandoned; in a WRITE cycle where flush is high, tbl_wren is still asserted (the write completes).
  - flush during INIT restarts the sweep at address 0.
  - upd_ready=0 in the flush cycle.
- upd_valid and flush in the same cycle: flush wins and the update is not accepted.

Decomposition:
- Shared package: state_t counter enum (the same one used by the prediction table), a counter next-state function, and the N_TAKE init constant. The predictor table and this block both import it.
- One sub-module, bpt_update_fifo: synchronous FIFO of {index, mispredict}, fifo_depth entries, with push, pop, clear, full, empty and count.
- The FSM, sweep counter and port mux stay in bpt_update_scheduler.

Test Plan:
- s_index=3, release rst -> 8 cycles with tbl_wren=1, tbl_addr 0..7, tbl_wdata=0; then init_busy=0, tbl_wren=0, upd_ready=1.
- After init, push index 5 with mispredict=1 and model tbl_rdata=0 -> READ: addr 5, wren 0; WRITE: addr 5, wren 1, wdata 2.
- fifo_depth=4, push 8 updates on consecutive cycles -> upd_ready drops when upd_pending=4; all 8 written in order, one write every 2 cycles; none lost.
- Two updates to index 3 (correct, then mispredict), rdata modelled as table contents starting at TAKE(2) -> writes 3 (STRONG_TAKE), then 2 (TAKE).
- flush in a WRITE cycle with 2 entries queued -> that write still happens; next cycle INIT at addr 0, upd_pending=0; the queued updates are never written.
- Update accepted during INIT -> upd_dropped pulses; after the sweep, no write to that index.
- Assert rst low mid-READ -> tbl_wren=0 and init_busy=1 immediately; the sweep restarts at 0 after release.
